// File: rtl/dmem_pkg.sv
// Shared encodings, FSM state type and alignment helper for the RV32 data memory LSU.
package dmem_pkg;

    localparam int DMEM_XLEN = 32;

    localparam logic [1:0] SZ_BYTE    = 2'b00;
    localparam logic [1:0] SZ_HALF    = 2'b01;
    localparam logic [1:0] SZ_WORD    = 2'b10;
    localparam logic [1:0] SZ_ILLEGAL = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BEAT2 = 2'd1,
        ST_RESP  = 2'd2
    } state_e;

    // An access is misaligned when its bytes spill past the end of the addressed word.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            SZ_HALF: return (lane == 2'd3);
            SZ_WORD: return (lane != 2'd0);
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane alignment over a two-word window: store byte enables and left shift,
// plus load extraction with sign/zero extension.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [1:0]  lane_i,
    input  logic        unsigned_i,
    input  logic [63:0] data_i,
    output logic [7:0]  be_o,
    output logic [63:0] shl_o,
    output logic [31:0] ext_o
);

    logic [3:0]  baseMask;
    logic [5:0]  shamt;
    logic [63:0] shr;
    logic        unusedShr;

    assign unusedShr = ^shr[63:32];

    always_comb begin
        case (size_i)
            SZ_BYTE: baseMask = 4'b0001;
            SZ_HALF: baseMask = 4'b0011;
            SZ_WORD: baseMask = 4'b1111;
            default: baseMask = 4'b0000;
        endcase
        shamt = {1'b0, lane_i, 3'b000};
        be_o  = {4'b0000, baseMask} << lane_i;
        shl_o = data_i << shamt;
        shr   = data_i >> shamt;
        case (size_i)
            SZ_BYTE: ext_o = {{24{shr[7] & ~unsigned_i}}, shr[7:0]};
            SZ_HALF: ext_o = {{16{shr[15] & ~unsigned_i}}, shr[15:0]};
            SZ_WORD: ext_o = shr[31:0];
            default: ext_o = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/data_memory_lsu.sv
// Word-organised RV32 data memory with byte lanes behind a valid/ready LSU interface.
// Define DMEM_MISALIGN_SPLIT_EN to split misaligned accesses into two beats; otherwise they return rsp_err.
module data_memory_lsu
    import dmem_pkg::*;
#(
    parameter int DEPTH      = 256,
    parameter int ADDR_WIDTH = $clog2(DEPTH) + 2,
    parameter int XLEN       = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [XLEN-1:0]       req_wdata,
    output logic                  rsp_valid,
    output logic [XLEN-1:0]       rsp_rdata,
    output logic                  rsp_err
);

    localparam int WW = $clog2(DEPTH);

    state_e          state_q;
    logic            ready_q;
    logic            rspValid_q;
    logic            rspErr_q;
    logic [XLEN-1:0] rspRdata_q;
    logic [31:0]     mem_q [DEPTH];

    logic          accept;
    logic [WW-1:0] reqWord;
    logic [1:0]    reqLane;
    logic          reqMis;
    logic          reqErr;
    logic          writeLo;
    logic [1:0]    curSize;
    logic [1:0]    curLane;
    logic          curUnsigned;
    logic [31:0]   curWdata;
    logic [63:0]   loadWin;
    logic [7:0]    stBe;
    logic [7:0]    ldBe;
    logic [63:0]   stShl;
    logic [63:0]   ldShl;
    logic [31:0]   stExt;
    logic [31:0]   ldExt;
    logic          unusedBits;

    assign accept  = req_valid && ready_q;
    assign reqWord = req_addr[ADDR_WIDTH-1:2];
    assign reqLane = req_addr[1:0];
    assign reqMis  = is_misaligned(req_size, reqLane);
    assign writeLo = accept && req_we && !reqErr;

`ifdef DMEM_MISALIGN_SPLIT_EN
    logic [WW-1:0] wordIdx_q;
    logic [1:0]    size_q;
    logic [1:0]    lane_q;
    logic          unsigned_q;
    logic          we_q;
    logic [31:0]   wdata_q;
    logic [31:0]   partial_q;
    logic [WW-1:0] wordNext;
    logic          inBeat2;
    logic          writeHi;

    // Beat 2 replays the latched request against the following word, wrapping at DEPTH.
    assign inBeat2     = (state_q == ST_BEAT2);
    assign wordNext    = wordIdx_q + 1'b1;
    assign curSize     = inBeat2 ? size_q : req_size;
    assign curLane     = inBeat2 ? lane_q : reqLane;
    assign curUnsigned = inBeat2 ? unsigned_q : req_unsigned;
    assign curWdata    = inBeat2 ? wdata_q : req_wdata;
    assign loadWin     = inBeat2 ? {mem_q[wordNext], partial_q} : {32'h0, mem_q[reqWord]};
    assign writeHi     = inBeat2 && we_q;
    assign reqErr      = (req_size == SZ_ILLEGAL);
`else
    assign curSize     = req_size;
    assign curLane     = reqLane;
    assign curUnsigned = req_unsigned;
    assign curWdata    = req_wdata;
    assign loadWin     = {32'h0, mem_q[reqWord]};
    assign reqErr      = (req_size == SZ_ILLEGAL) || reqMis;
`endif

    dmem_lane_align u_store_align (
        .size_i     (curSize),
        .lane_i     (curLane),
        .unsigned_i (curUnsigned),
        .data_i     ({32'h0, curWdata}),
        .be_o       (stBe),
        .shl_o      (stShl),
        .ext_o      (stExt)
    );

    dmem_lane_align u_load_align (
        .size_i     (curSize),
        .lane_i     (curLane),
        .unsigned_i (curUnsigned),
        .data_i     (loadWin),
        .be_o       (ldBe),
        .shl_o      (ldShl),
        .ext_o      (ldExt)
    );

    assign unusedBits = ^{stExt, ldBe, ldShl, stBe[7:4], stShl[63:32]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 32'h0;
            end
        end else begin
            for (int b = 0; b < 4; b++) begin
                if (writeLo && stBe[b]) begin
                    mem_q[reqWord][8*b +: 8] <= stShl[8*b +: 8];
                end
`ifdef DMEM_MISALIGN_SPLIT_EN
                if (writeHi && stBe[4+b]) begin
                    mem_q[wordNext][8*b +: 8] <= stShl[32+8*b +: 8];
                end
`endif
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            ready_q    <= 1'b0;
            rspValid_q <= 1'b0;
            rspErr_q   <= 1'b0;
            rspRdata_q <= '0;
`ifdef DMEM_MISALIGN_SPLIT_EN
            wordIdx_q  <= '0;
            size_q     <= SZ_BYTE;
            lane_q     <= 2'd0;
            unsigned_q <= 1'b0;
            we_q       <= 1'b0;
            wdata_q    <= 32'h0;
            partial_q  <= 32'h0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    ready_q <= 1'b1;
                    if (accept) begin
                        ready_q <= 1'b0;
`ifdef DMEM_MISALIGN_SPLIT_EN
                        wordIdx_q  <= reqWord;
                        size_q     <= req_size;
                        lane_q     <= reqLane;
                        unsigned_q <= req_unsigned;
                        we_q       <= req_we;
                        wdata_q    <= req_wdata;
`endif
                        if (reqErr) begin
                            rspValid_q <= 1'b1;
                            rspErr_q   <= 1'b1;
                            rspRdata_q <= '0;
                            state_q    <= ST_RESP;
                        end
`ifdef DMEM_MISALIGN_SPLIT_EN
                        else if (reqMis) begin
                            partial_q <= mem_q[reqWord];
                            state_q   <= ST_BEAT2;
                        end
`endif
                        else begin
                            rspValid_q <= 1'b1;
                            rspErr_q   <= 1'b0;
                            rspRdata_q <= req_we ? '0 : ldExt;
                            state_q    <= ST_RESP;
                        end
                    end
                end
`ifdef DMEM_MISALIGN_SPLIT_EN
                ST_BEAT2: begin
                    rspValid_q <= 1'b1;
                    rspErr_q   <= 1'b0;
                    rspRdata_q <= we_q ? '0 : ldExt;
                    state_q    <= ST_RESP;
                end
`endif
                ST_RESP: begin
                    rspValid_q <= 1'b0;
                    ready_q    <= 1'b1;
                    state_q    <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready = ready_q;
    assign rsp_valid = rspValid_q;
    assign rsp_rdata = rspRdata_q;
    assign rsp_err   = rspErr_q;

endmodule

// File: tb/tb_data_memory_lsu.sv
// Scoreboard bench for data_memory_lsu against a byte-array reference model;
// expectations follow DMEM_MISALIGN_SPLIT_EN when it is defined.
module tb_data_memory_lsu;

    localparam int DEPTH    = 256;
    localparam int AW       = 10;
    localparam int MEMBYTES = DEPTH * 4;

    typedef struct {
        string       name;
        logic [31:0] data;
        logic        err;
        int          lat;
        int          acc;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_we = 1'b0;
    logic [1:0]    req_size = 2'b00;
    logic          req_unsigned = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [31:0]   req_wdata = 32'h0;
    logic          rsp_valid;
    logic [31:0]   rsp_rdata;
    logic          rsp_err;

    exp_t        expQ[$];
    exp_t        mon;
    logic [7:0]  modelMem [MEMBYTES];
    int          tests = 0;
    int          fails = 0;
    int          cycle = 0;
    int          lastAcc = 0;
    int          prevAcc = 0;

    data_memory_lsu #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, expv);
        end
    endtask

    // Reference: the access touches n consecutive byte addresses modulo memory size.
    function automatic void modelAccess(input bit we, input logic [1:0] size, input bit uns,
                                        input logic [AW-1:0] addr, input logic [31:0] wdata,
                                        output logic [31:0] data, output logic err, output int lat);
        int n;
        int idx;
        bit crosses;
        logic [31:0] v;
        data = 32'h0;
        err  = 1'b0;
        lat  = 1;
        v    = 32'h0;
        if (size == 2'b11) begin
            err = 1'b1;
            return;
        end
        n = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
        crosses = (int'(addr[1:0]) + n) > 4;
`ifndef DMEM_MISALIGN_SPLIT_EN
        if (crosses) begin
            err = 1'b1;
            return;
        end
`endif
        lat = crosses ? 2 : 1;
        for (int i = 0; i < n; i++) begin
            idx = (int'(addr) + i) % MEMBYTES;
            if (we) modelMem[idx] = wdata[8*i +: 8];
            else v[8*i +: 8] = modelMem[idx];
        end
        if (!we) begin
            if (n == 1 && !uns) v = {{24{v[7]}}, v[7:0]};
            if (n == 2 && !uns) v = {{16{v[15]}}, v[15:0]};
            data = v;
        end
    endfunction

    task automatic clearModel();
        for (int i = 0; i < MEMBYTES; i++) modelMem[i] = 8'h00;
    endtask

    task automatic applyStimulus(input string name, input bit push, input bit we, input logic [1:0] size,
                                 input bit uns, input logic [AW-1:0] addr, input logic [31:0] wdata,
                                 input bit useConst, input logic [31:0] cData, input bit cErr);
        exp_t x;
        int budget;
        logic [31:0] d;
        logic er;
        int lt;
        @(negedge clk);
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        budget = 0;
        while (req_ready !== 1'b1 && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        if (req_ready !== 1'b1) begin
            tests++;
            fails++;
            $display("[TB] FAIL %s_accept: got req_ready=%b, expected 1 within 50 cycles", name, req_ready);
            req_valid = 1'b0;
            return;
        end
        lastAcc = cycle;
        if (push) begin
            modelAccess(we, size, uns, addr, wdata, d, er, lt);
            x.name = name;
            x.data = useConst ? cData : d;
            x.err  = useConst ? cErr : er;
            x.lat  = lt;
            x.acc  = cycle;
            expQ.push_back(x);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idleBus();
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    // Monitor: every response pops the oldest expectation.
    always @(negedge clk) begin
        if (rsp_valid === 1'b1) begin
            if (expQ.size() == 0) begin
                tests++;
                fails++;
                $display("[TB] FAIL unexpected_rsp: got rsp_valid=1 with rdata 0x%08h, expected no response", rsp_rdata);
            end else begin
                mon = expQ.pop_front();
                checkOutput({mon.name, "_rdata"}, rsp_rdata, mon.data);
                checkOutput({mon.name, "_err"}, {31'h0, rsp_err}, {31'h0, mon.err});
                checkOutput({mon.name, "_latency"}, 32'(cycle - mon.acc), 32'(mon.lat));
            end
        end
    end

    initial begin
        logic [1:0]  rs;
        logic [AW-1:0] ra;
        int r;
        int budget;
        clearModel();
        #2 rst = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("reset_ready", {31'h0, req_ready}, 32'h0);
        checkOutput("reset_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        checkOutput("reset_rsp_rdata", rsp_rdata, 32'h0);
        checkOutput("reset_rsp_err", {31'h0, rsp_err}, 32'h0);
        rst = 1'b0;
        #1 checkOutput("release_ready_low", {31'h0, req_ready}, 32'h0);
        @(posedge clk);
        #1 checkOutput("release_ready_high", {31'h0, req_ready}, 32'h1);

        // Reset in the middle of a misaligned store abandons it and wipes the first beat.
        applyStimulus("abandoned_sw", 0, 1, 2'b10, 0, 10'h3FE, 32'hAABBCCDD, 0, 32'h0, 0);
        rst = 1'b1;
        req_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checkOutput("midreset_ready", {31'h0, req_ready}, 32'h0);
            checkOutput("midreset_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        end
        rst = 1'b0;
        clearModel();
        applyStimulus("lw_after_reset", 1, 0, 2'b10, 0, 10'h000, 32'h0, 1, 32'h0, 0);
        applyStimulus("lw3fc_after_reset", 1, 0, 2'b10, 0, 10'h3FC, 32'h0, 1, 32'h0, 0);

        applyStimulus("sw_010", 1, 1, 2'b10, 0, 10'h010, 32'hDEADBEEF, 1, 32'h0, 0);
        applyStimulus("lw_010", 1, 0, 2'b10, 0, 10'h010, 32'h0, 1, 32'hDEADBEEF, 0);

        applyStimulus("sb_021", 1, 1, 2'b00, 0, 10'h021, 32'h00000080, 1, 32'h0, 0);
        applyStimulus("lb_021", 1, 0, 2'b00, 0, 10'h021, 32'h0, 1, 32'hFFFFFF80, 0);
        applyStimulus("lbu_021", 1, 0, 2'b00, 1, 10'h021, 32'h0, 1, 32'h00000080, 0);
        applyStimulus("lw_020", 1, 0, 2'b10, 0, 10'h020, 32'h0, 1, 32'h00008000, 0);

        applyStimulus("sw_3fe", 1, 1, 2'b10, 0, 10'h3FE, 32'h11223344, 0, 32'h0, 0);
`ifdef DMEM_MISALIGN_SPLIT_EN
        applyStimulus("lw_3fe", 1, 0, 2'b10, 0, 10'h3FE, 32'h0, 1, 32'h11223344, 0);
        applyStimulus("lw_3fc", 1, 0, 2'b10, 0, 10'h3FC, 32'h0, 1, 32'h33440000, 0);
        applyStimulus("lw_000_wrap", 1, 0, 2'b10, 0, 10'h000, 32'h0, 1, 32'h00001122, 0);
        applyStimulus("lh_003", 1, 0, 2'b01, 0, 10'h003, 32'h0, 1, 32'h0, 0);
        applyStimulus("lw_000_after_lh", 1, 0, 2'b10, 0, 10'h000, 32'h0, 1, 32'h00001122, 0);
`else
        applyStimulus("lw_3fe", 1, 0, 2'b10, 0, 10'h3FE, 32'h0, 1, 32'h0, 1);
        applyStimulus("lw_3fc", 1, 0, 2'b10, 0, 10'h3FC, 32'h0, 1, 32'h0, 0);
        applyStimulus("lw_000_wrap", 1, 0, 2'b10, 0, 10'h000, 32'h0, 1, 32'h0, 0);
        applyStimulus("lh_003", 1, 0, 2'b01, 0, 10'h003, 32'h0, 1, 32'h0, 1);
        applyStimulus("lw_000_after_lh", 1, 0, 2'b10, 0, 10'h000, 32'h0, 1, 32'h0, 0);
`endif

        // Illegal size with req_valid held high: one accept every two cycles.
        for (int k = 0; k < 4; k++) begin
            prevAcc = lastAcc;
            applyStimulus("illegal_sw_040", 1, 1, 2'b11, 0, 10'h040, 32'hFFFFFFFF, 1, 32'h0, 1);
            if (k > 0) checkOutput("illegal_spacing", 32'(lastAcc - prevAcc), 32'd2);
        end
        applyStimulus("lw_040", 1, 0, 2'b10, 0, 10'h040, 32'h0, 1, 32'h0, 0);
        idleBus();

        for (int k = 0; k < 300; k++) begin
            r  = $urandom_range(0, 9);
            rs = (r < 3) ? 2'b00 : (r < 6) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
            ra = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 63)) : AW'(1023 - $urandom_range(0, 63));
            applyStimulus("rand", 1, 1'($urandom_range(0, 1)), rs, 1'($urandom_range(0, 1)), ra, $urandom, 0, 32'h0, 0);
            if ($urandom_range(0, 3) == 0) idleBus();
        end
        idleBus();

        budget = 0;
        while (expQ.size() != 0 && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        if (expQ.size() != 0) begin
            tests++;
            fails++;
            $display("[TB] FAIL drain: got %0d outstanding responses, expected 0", expQ.size());
        end
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
